// File: rtl/mul_iter_unit.sv
// ---------------------------------------------------------------------------
// mul_iter_unit
//
// Multi-cycle integer multiplier for the EXE stage. It uses a radix-2
// shift-add engine that retires one multiplier bit per cycle, and returns
// the low half, the signed high half, or the unsigned high half of the
// product.
//
// Operands are converted to unsigned magnitudes at acceptance, and the
// engine multiplies those magnitudes. The sign is applied to the full
// 2*WIDTH-bit product on the final iteration. Because the magnitude is
// WIDTH bits unsigned, the most-negative operand maps to 2^(WIDTH-1)
// without overflow.
//
// Optional feature (macro MUL_ZERO_BYPASS_EN):
//   When the macro is defined, an accepted request with a zero operand goes
//   straight from IDLE to DONE with a result of 0. Without the macro, such
//   a request runs every iteration and still produces 0.
//
// Parameters:
//   WIDTH  operand/result width; must be even and >= 4
//   CNT_W  iteration counter width; derived from WIDTH, do not override
//
// Ports:
//   clk         clock
//   reset       synchronous, active-high reset
//   in_valid    request valid
//   in_ready    unit can accept a request (IDLE and no flush)
//   mul_op      one-hot op: [0] low half, [1] signed high, [2] unsigned high
//   mul_src1    multiplicand
//   mul_src2    multiplier
//   flush       cancel any in-flight operation
//   out_valid   result valid (DONE)
//   out_ready   consumer takes the result
//   mul_result  selected result half, held until taken
//   busy        state is not IDLE
// ---------------------------------------------------------------------------
module mul_iter_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       mul_op,
  input  logic [WIDTH-1:0] mul_src1,
  input  logic [WIDTH-1:0] mul_src2,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] mul_result,
  output logic             busy
);

  // state  | meaning
  // S_IDLE | waiting for a request; in_ready high unless flushing
  // S_BUSY | shift-add iterations running, counter counts down
  // S_DONE | result valid, held until out_ready
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [2:0]       op_q;
  logic             neg_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] mul_result_q;

  logic               accept;
  logic               zero_opnd;
  logic               last_iter;
  logic               sgn;
  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   mag2;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_sgn;
  logic [WIDTH-1:0]   res_sel;

  // -------------------------------------------------------------------------
  // Acceptance-time operand conditioning
  // -------------------------------------------------------------------------
  assign accept = in_valid & in_ready;
  assign sgn    = mul_op[1];
  assign mag1   = (sgn & mul_src1[WIDTH-1]) ? (~mul_src1 + WIDTH'(1)) : mul_src1;
  assign mag2   = (sgn & mul_src2[WIDTH-1]) ? (~mul_src2 + WIDTH'(1)) : mul_src2;

`ifdef MUL_ZERO_BYPASS_EN
  assign zero_opnd = (mul_src1 == '0) | (mul_src2 == '0);
`else
  assign zero_opnd = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Shift-add step. The sum is one bit wider than acc to keep the carry.
  // After the right shift, the full product register is {sum, b_q[W-1:1]},
  // so the final product can be taken from this cycle's step directly.
  // -------------------------------------------------------------------------
  assign sum       = {1'b0, acc_q} + {1'b0, (b_q[0] ? a_q : '0)};
  assign prod      = {sum, b_q[WIDTH-1:1]};
  assign prod_sgn  = neg_q ? (~prod + (2*WIDTH)'(1)) : prod;
  assign res_sel   = (op_q[0] ? prod_sgn[WIDTH-1:0] : '0) |
                     ((op_q[1] | op_q[2]) ? prod_sgn[2*WIDTH-1:WIDTH] : '0);
  assign last_iter = (state_q == S_BUSY) && (cnt_q == CNT_W'(1));

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state (flush beats everything but reset)
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_d = zero_opnd ? S_DONE : S_BUSY;
          end
        end
        S_BUSY: begin
          if (last_iter) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q == S_IDLE) & ~flush;
    busy      = (state_q != S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // -------------------------------------------------------------------------
  // Datapath. A flush freezes the engine, so mul_result keeps its stale value.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q         <= '0;
      neg_q        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      mul_result_q <= '0;
    end else if (accept) begin
      op_q  <= mul_op;
      neg_q <= sgn & (mul_src1[WIDTH-1] ^ mul_src2[WIDTH-1]);
      a_q   <= mag1;
      b_q   <= mag2;
      acc_q <= '0;
      cnt_q <= CNT_W'(WIDTH);
      if (zero_opnd) begin
        mul_result_q <= '0;
      end
    end else if ((state_q == S_BUSY) && !flush) begin
      acc_q <= sum[WIDTH:1];
      b_q   <= {sum[0], b_q[WIDTH-1:1]};
      cnt_q <= cnt_q - CNT_W'(1);
      if (last_iter) begin
        mul_result_q <= res_sel;
      end
    end
  end

  assign mul_result = mul_result_q;

endmodule

// File: tb/tb_mul_iter_unit.sv
module tb_mul_iter_unit;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   mul_op;
  logic [W-1:0] mul_src1;
  logic [W-1:0] mul_src2;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] mul_result;
  logic         busy;

  int checks;
  int failures;

  mul_iter_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mul_op     (mul_op),
    .mul_src1   (mul_src1),
    .mul_src2   (mul_src2),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .mul_result (mul_result),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [W-1:0] s1;
    logic [W-1:0] s2;
    logic [W-1:0] exp;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Present a request at a falling edge; acceptance happens at the next rising edge.
  task automatic start_op(input logic [2:0] op, input logic [W-1:0] s1, input logic [W-1:0] s2);
    @(negedge clk);
    in_valid = 1'b1;
    mul_op   = op;
    mul_src1 = s1;
    mul_src2 = s2;
    #1;
    check("accept_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
  endtask

  // Count falling edges after acceptance until out_valid; scramble the inputs on the first one.
  task automatic wait_done(output int lat, output bit ready_low);
    lat       = 0;
    ready_low = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) begin
        in_valid = 1'b0;
        mul_op   = 3'b111;
        mul_src1 = $urandom;
        mul_src2 = $urandom;
      end
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
      if (in_ready) ready_low = 1'b0;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("release_out_valid", {31'b0, out_valid}, 32'd0);
    check("release_in_ready", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    int        lat;
    int        exp_lat;
    bit        rl;
    logic [W-1:0] held;
    bit        saw_valid;

    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    mul_op    = 3'b000;
    mul_src1  = '0;
    mul_src2  = '0;
    flush     = 1'b0;
    out_ready = 1'b0;

    vecs[0]  = '{"mulw_7_m3",       3'b001, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB};
    vecs[1]  = '{"mulhw_min_min",   3'b010, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[2]  = '{"mulw_min_min",    3'b001, 32'h80000000, 32'h80000000, 32'h00000000};
    vecs[3]  = '{"mulhw_min_1",     3'b010, 32'h80000000, 32'h00000001, 32'hFFFFFFFF};
    vecs[4]  = '{"mulhwu_ff_ff",    3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[5]  = '{"mulhw_ff_ff",     3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[6]  = '{"mulw_ff_ff",      3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[7]  = '{"mulhw_7_m3",      3'b010, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF};
    vecs[8]  = '{"mulhwu_7_m3",     3'b100, 32'h00000007, 32'hFFFFFFFD, 32'h00000006};
    vecs[9]  = '{"mulw_shift",      3'b001, 32'h12345678, 32'h00000010, 32'h23456780};
    vecs[10] = '{"op_zero",         3'b000, 32'h12345678, 32'h00000010, 32'h00000000};
    vecs[11] = '{"op_lo_hi_or",     3'b011, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF};
    vecs[12] = '{"mulhw_max_max",   3'b010, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF};
    vecs[13] = '{"mulw_src2_zero",  3'b001, 32'h00001234, 32'h00000000, 32'h00000000};
    vecs[14] = '{"mulhw_src1_zero", 3'b010, 32'h00000000, 32'h80000000, 32'h00000000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_mul_result", mul_result, 32'd0);

    for (int i = 0; i < NVEC; i++) begin
      exp_lat = 33;
`ifdef MUL_ZERO_BYPASS_EN
      if (vecs[i].s1 == '0 || vecs[i].s2 == '0) exp_lat = 1;
`endif
      start_op(vecs[i].op, vecs[i].s1, vecs[i].s2);
      wait_done(lat, rl);
      check({vecs[i].name, "_latency"}, lat, exp_lat);
      check({vecs[i].name, "_result"}, mul_result, vecs[i].exp);
      check({vecs[i].name, "_in_ready_low"}, {31'b0, rl}, 32'd1);
      release_out();
    end

    // Hold the result in DONE; a pulsed in_valid must be ignored.
    start_op(3'b001, 32'h00000007, 32'hFFFFFFFD);
    wait_done(lat, rl);
    check("hold_latency", lat, 33);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = (k == 2);
      mul_op   = 3'b001;
      mul_src1 = 32'h3;
      mul_src2 = 32'h5;
      #1;
      check("hold_out_valid", {31'b0, out_valid}, 32'd1);
      check("hold_result", mul_result, 32'hFFFFFFEB);
      check("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    release_out();
    @(negedge clk);
    #1;
    check("hold_no_issue_busy", {31'b0, busy}, 32'd0);

    // Flush at iteration 10 of BUSY.
    start_op(3'b100, 32'h00010000, 32'h00010000);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) in_valid = 1'b0;
    end
    #1;
    check("flush_busy_before", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    #1;
    check("flush_in_ready_low", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_busy_after", {31'b0, busy}, 32'd0);
    check("flush_in_ready_after", {31'b0, in_ready}, 32'd1);
    check("flush_stale_result", mul_result, 32'hFFFFFFEB);
    saw_valid = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("flush_no_out_valid", {31'b0, saw_valid}, 32'd0);
    start_op(3'b100, 32'h00010000, 32'h00010000);
    wait_done(lat, rl);
    check("flush_recover_latency", lat, 33);
    check("flush_recover_result", mul_result, 32'h00000001);
    release_out();

    // Reset at iteration 10 of BUSY.
    start_op(3'b001, 32'h00000007, 32'hFFFFFFFD);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) in_valid = 1'b0;
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_mul_result", mul_result, 32'd0);
    start_op(3'b100, 32'h00010000, 32'h00010000);
    wait_done(lat, rl);
    check("rst_recover_latency", lat, 33);
    check("rst_recover_result", mul_result, 32'h00000001);

    // Flush while in DONE drops out_valid; the stale result stays.
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_done_out_valid", {31'b0, out_valid}, 32'd0);
    check("flush_done_stale", mul_result, 32'h00000001);

    // in_valid together with flush in IDLE is dropped.
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    mul_op   = 3'b001;
    mul_src1 = 32'h2;
    mul_src2 = 32'h3;
    #1;
    check("flush_idle_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("flush_idle_dropped", {31'b0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
